// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder: one full-adder stage per cycle, LSB first, with a
// start/busy/done handshake. The result registers update only when an add completes.
module serial_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             h1_s_c;
    logic             h1_c_c;
    logic             h2_c_c;
    logic             s_c;
    logic             c_next_c;
    logic [WIDTH-1:0] acc_next_c;
    logic             last_c;

    // Full adder built from two half adders and an OR on the current LSB pair
    always_comb begin
        h1_s_c     = ra[0] ^ rb[0];
        h1_c_c     = ra[0] & rb[0];
        s_c        = h1_s_c ^ c;
        h2_c_c     = h1_s_c & c;
        c_next_c   = h1_c_c | h2_c_c;
        acc_next_c = {s_c, acc[WIDTH-1:1]};
        last_c     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done track the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        c   <= cin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    ra  <= {1'b0, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    acc <= acc_next_c;
                    c   <= c_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_c) begin
                        sum  <= acc_next_c;
                        cout <= c_next_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add at WIDTH=2, 8 and 16 against an arithmetic
// reference ({cout,sum} == a+b+cin) plus handshake timing checks at WIDTH=8.
module tb_serial_add;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic        busy2, done2, cout2;
    logic [1:0]  sum2;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    logic [2:0]  done_v;
    logic [2:0]  busy_v;

    int total = 0;
    int bad   = 0;

    serial_add #(.WIDTH(2)) u_add2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a[1:0]), .b(b[1:0]), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_add #(.WIDTH(8)) u_add8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add #(.WIDTH(16)) u_add16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    assign done_v = {done16, done8, done2};
    assign busy_v = {busy16, busy8, busy2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint get_res(input int idx);
        case (idx)
            0:       return longint'({cout2, sum2});
            1:       return longint'({cout8, sum8});
            default: return longint'({cout16, sum16});
        endcase
    endfunction

    function automatic int width_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    // Pulse start on one instance, scramble operands after capture, wait for done
    task automatic do_add(input int idx, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, output longint res, output int lat, output int bcnt);
        @(negedge clk);
        a = av;
        b = bv;
        cin = ci;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        lat = 1;
        bcnt = int'(busy_v[idx]);
        while (!done_v[idx] && lat < 64) begin
            @(negedge clk);
            lat++;
            bcnt += int'(busy_v[idx]);
        end
        res = get_res(idx);
    endtask

    function automatic longint ref_add(input int w, input logic [15:0] av,
                                       input logic [15:0] bv, input logic ci);
        longint m;
        m = (longint'(1) << w) - 1;
        return (longint'(av) & m) + (longint'(bv) & m) + longint'(ci);
    endfunction

    initial begin
        longint res;
        int     lat;
        int     bcnt;
        int     n;
        int     ndone;
        logic [15:0] av, bv;
        logic        ci;

        rst = 1'b1;
        start_v = '0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_sum16", sum16, 0);
        rst = 1'b0;

        // T1: basic add with latency and busy-length checks
        do_add(1, 16'd3, 16'd5, 1'b0, res, lat, bcnt);
        check("t1_res", res, 8);
        check("t1_lat", lat, 9);
        check("t1_busy_cycles", bcnt, 9);
        @(negedge clk);
        check("t1_idle_busy", busy8, 0);
        check("t1_idle_done", done8, 0);
        check("t1_hold_sum", sum8, 8);

        // T2: boundary additions
        do_add(1, 16'd255, 16'd1, 1'b0, res, lat, bcnt);
        check("t2_ones_plus1", res, 256);
        do_add(1, 16'd0, 16'd0, 1'b1, res, lat, bcnt);
        check("t2_zero_cin", res, 1);
        do_add(1, 16'd255, 16'd255, 1'b1, res, lat, bcnt);
        check("t2_ones_ones_cin", res, 511);

        // T3: a second start during SHIFT is ignored
        @(negedge clk);
        a = 16'd100;
        b = 16'd27;
        cin = 1'b0;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        repeat (2) @(negedge clk);
        start_v[1] = 1'b1;
        a = 16'd1;
        b = 16'd1;
        @(negedge clk);
        start_v[1] = 1'b0;
        ndone = 0;
        res = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                res = get_res(1);
            end
        end
        check("t3_done_count", ndone, 1);
        check("t3_res", res, 127);

        // T4: reset mid-operation aborts immediately without a done pulse
        @(negedge clk);
        a = 16'd77;
        b = 16'd99;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_busy", busy8, 0);
        check("t4_done", done8, 0);
        check("t4_sum", sum8, 0);
        check("t4_cout", cout8, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("t4_no_done", ndone, 0);
        do_add(1, 16'd10, 16'd20, 1'b0, res, lat, bcnt);
        check("t4_after_rst", res, 30);

        // T5: start held high gives one result every WIDTH+2 cycles
        @(negedge clk);
        a = 16'd200;
        b = 16'd100;
        cin = 1'b0;
        start_v[1] = 1'b1;
        n = 0;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_done", done8, 1);
        check("t5_first_res", get_res(1), 300);
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                check("t5_hold", get_res(1), 300);
            end while (!done8 && n < 30);
            check("t5_period", n, 10);
        end
        start_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_idle", busy8, 0);

        // T6: random scoreboard at each width
        for (int idx = 0; idx < 3; idx++) begin
            for (int k = 0; k < 1000; k++) begin
                av = 16'($urandom);
                bv = 16'($urandom);
                ci = 1'($urandom);
                do_add(idx, av, bv, ci, res, lat, bcnt);
                check($sformatf("t6_w%0d_res", width_of(idx)), res,
                      ref_add(width_of(idx), av, bv, ci));
                check($sformatf("t6_w%0d_lat", width_of(idx)), lat, width_of(idx) + 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
